mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline.
- Sits between the EX_MEM and MEM_WB pipeline registers and consumes EX_MEM outputs directly.
- Runs LB/LH/LW/LBU/LHU/SB/SH/SW as byte-serial transfers on the 8-bit RAM port, and raises a stall while a transfer is in flight.
- For non-memory instructions it passes the EX result through to MEM_WB in zero cycles.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_stage_if.sv | 17 +
 rtl/mem_stage_load_extend.sv | 25 ++
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage.
// Contents: funct3 load/store size codes, FSM state encodings, the RAM
// byte width and a helper that maps funct3[1:0] to a transfer length.
package mem_stage_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    localparam int RamDataLen = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2
    } mem_state_t;

    // Number of bytes moved for a given size code; the reserved code 11
    // behaves as a word.
    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        case (size)
            FUNCT3_B[1:0]: xfer_len = 3'd1;
            FUNCT3_H[1:0]: xfer_len = 3'd2;
            FUNCT3_W[1:0]: xfer_len = 3'd4;
            default:       xfer_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide RAM port used by the MEM stage.
// Signals: ram_addr (byte address), ram_dout (write byte), ram_wr (write
// strobe), ram_din (read byte, valid one cycle after its address).
// master = MEM stage side, slave = RAM side.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]     ram_addr;
    logic [RamDataLen-1:0] ram_dout;
    logic                  ram_wr;
    logic [RamDataLen-1:0] ram_din;

    modport master (output ram_addr, output ram_dout, output ram_wr, input ram_din);
    modport slave  (input ram_addr, input ram_dout, input ram_wr, output ram_din);
endinterface

// File: rtl/mem_stage_load_extend.sv
// Load result assembly for the MEM stage (combinational).
// Ports: lo_bytes (bytes 0..2 already collected), last_byte (final byte,
// straight from the RAM), funct3 (size + unsigned flag), data (32-bit
// sign/zero extended result).
module mem_load_extend
    import mem_stage_pkg::*;
(
    input  logic [2:0][RamDataLen-1:0] lo_bytes,
    input  logic [RamDataLen-1:0]      last_byte,
    input  logic [2:0]                 funct3,
    output logic [31:0]                data
);
    logic fill;

    always_comb begin
        // The last byte received is always the most significant one.
        fill = ~funct3[2] & last_byte[7];
        data = {last_byte, lo_bytes};
        case (funct3[1:0])
            FUNCT3_B[1:0]: data = {{24{fill}}, last_byte};
            FUNCT3_H[1:0]: data = {{16{fill}}, last_byte, lo_bytes[0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32I pipeline.
// Loads and stores run byte-serially over an 8-bit RAM port (little-endian,
// wrapping addresses) while stall_req holds the upstream stages, so the
// mem_* inputs are stable for the whole transfer. Non-memory instructions
// pass straight to the wb_* outputs in the same cycle.
// Ports: clk, rst (async, active-high), rdy (global freeze), mem_* (EX_MEM
// outputs), ram (byte RAM port), stall_req, wb_* (to MEM_WB).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_load_enable,
    input  logic              mem_store_enable,
    input  logic [ADDR_W-1:0] mem_load_store_addr,
    input  logic [2:0]        mem_funct3,
    input  logic [4:0]        mem_rd_addr,
    input  logic              mem_rd_write_enable,
    mem_stage_if.master       ram,
    output logic              stall_req,
    output logic [DATA_W-1:0] wb_rd_data,
    output logic [4:0]        wb_rd_addr,
    output logic              wb_rd_write_enable
);
    mem_state_t                 state;
    logic [2:0]                 cnt;
    logic [2:0][RamDataLen-1:0] byte_buf;

    logic [2:0]            len;
    logic                  is_load;
    logic [2:0]            idx;
    logic [1:0]            buf_sel;
    logic                  load_last;
    logic [ADDR_W-1:0]     byte_addr;
    logic [RamDataLen-1:0] store_byte;
    logic [31:0]           load_word;

    assign len       = xfer_len(mem_funct3[1:0]);
    // A store wins when both enables are set.
    assign is_load   = mem_load_enable & ~mem_store_enable;
    assign load_last = (state == S_LOAD) && (cnt == len);
    assign buf_sel   = cnt[1:0] - 2'd1;

    // Byte index on the bus. cnt is kept at 0 in IDLE, so it doubles as the
    // first index. While a load is frozen the previous address is replayed
    // so ram_din still carries the byte the next capture expects.
    always_comb begin
        idx = cnt;
        if (state == S_LOAD && !rdy) idx = cnt - 3'd1;
    end

    assign byte_addr  = mem_load_store_addr + ADDR_W'(idx);
    assign store_byte = mem_data[{idx[1:0], 3'b000} +: RamDataLen];

    mem_load_extend u_extend (
        .lo_bytes  (byte_buf),
        .last_byte (ram.ram_din),
        .funct3    (mem_funct3),
        .data      (load_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            byte_buf <= '0;
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (mem_store_enable && len != 3'd1) begin
                        state <= S_STORE;
                        cnt   <= 3'd1;
                    end else if (is_load) begin
                        state <= S_LOAD;
                        cnt   <= 3'd1;
                    end
                end
                S_LOAD: begin
                    if (cnt == len) begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        byte_buf[buf_sel] <= ram.ram_din;
                        cnt               <= cnt + 3'd1;
                    end
                end
                S_STORE: begin
                    if (cnt == len - 3'd1) begin
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from state plus the held inputs so the first byte
    // goes out in the issue cycle and reset forces them low immediately.
    always_comb begin
        ram.ram_addr       = '0;
        ram.ram_dout       = '0;
        ram.ram_wr         = 1'b0;
        stall_req          = 1'b0;
        wb_rd_data         = mem_data;
        wb_rd_addr         = mem_rd_addr;
        wb_rd_write_enable = mem_rd_write_enable && (mem_rd_addr != 5'd0);
        if (rst) begin
            wb_rd_write_enable = 1'b0;
        end else if (mem_store_enable) begin
            ram.ram_addr       = byte_addr;
            ram.ram_dout       = store_byte;
            ram.ram_wr         = rdy;
            stall_req          = (idx != len - 3'd1);
            wb_rd_write_enable = 1'b0;
        end else if (mem_load_enable) begin
            ram.ram_addr       = byte_addr;
            stall_req          = ~load_last;
            wb_rd_data         = DATA_W'(load_word);
            wb_rd_write_enable = load_last && mem_rd_write_enable && (mem_rd_addr != 5'd0);
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected results, RAM
// writes and load read addresses; a negedge monitor compares them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] mem_data = '0;
    logic        mem_load_enable = 1'b0;
    logic        mem_store_enable = 1'b0;
    logic [31:0] mem_load_store_addr = '0;
    logic [2:0]  mem_funct3 = '0;
    logic [4:0]  mem_rd_addr = '0;
    logic        mem_rd_write_enable = 1'b0;
    logic        stall_req;
    logic [31:0] wb_rd_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_write_enable;

    mem_stage_if #(.ADDR_W(32)) ram_if ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .mem_data            (mem_data),
        .mem_load_enable     (mem_load_enable),
        .mem_store_enable    (mem_store_enable),
        .mem_load_store_addr (mem_load_store_addr),
        .mem_funct3          (mem_funct3),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_write_enable (mem_rd_write_enable),
        .ram                 (ram_if),
        .stall_req           (stall_req),
        .wb_rd_data          (wb_rd_data),
        .wb_rd_addr          (wb_rd_addr),
        .wb_rd_write_enable  (wb_rd_write_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 alu, 1 load, 2 store
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        int          stalls;
    } exp_t;
    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wq[$];
    logic [31:0] raq[$];
    int n_cmp = 0, n_fail = 0, done_cnt = 0, issued = 0, scnt = 0;
    bit end_chk = 0, end_done = 0;

    // RAM contents: 4 KiB aliased image, seeded with a few fixed bytes.
    function automatic logic [7:0] init_byte(input logic [11:0] a);
        case (a)
            12'h100: return 8'h78;
            12'h101: return 8'h56;
            12'h102: return 8'h34;
            12'h103: return 8'h12;
            12'h020: return 8'h80;
            12'h021: return 8'h80;
            12'h022: return 8'hFF;
            default: return 8'(a[7:0] * 8'd37) ^ {4'h0, a[11:8]} ^ 8'hA5;
        endcase
    endfunction

    // Physical RAM seen by the DUT.
    logic [7:0] pmem[4096];
    bit         pval[4096];
    function automatic logic [7:0] prd(input logic [31:0] a);
        return pval[a[11:0]] ? pmem[a[11:0]] : init_byte(a[11:0]);
    endfunction
    always @(posedge clk) begin
        if (ram_if.ram_wr) begin
            pmem[ram_if.ram_addr[11:0]] <= ram_if.ram_dout;
            pval[ram_if.ram_addr[11:0]] <= 1'b1;
        end
        ram_if.ram_din <= prd(ram_if.ram_addr);
    end

    // Reference memory image kept by the stimulus side.
    logic [7:0] mmem[4096];
    bit         mval[4096];
    function automatic logic [7:0] mrd(input logic [31:0] a);
        return mval[a[11:0]] ? mmem[a[11:0]] : init_byte(a[11:0]);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ram_wr", 32'(ram_if.ram_wr), 32'd0);
            chk("rst_stall", 32'(stall_req), 32'd0);
            chk("rst_ram_addr", ram_if.ram_addr, 32'd0);
            chk("rst_ram_dout", 32'(ram_if.ram_dout), 32'd0);
            chk("rst_wb_we", 32'(wb_rd_write_enable), 32'd0);
            scnt = 0;
        end else if (!rdy) begin
            chk("frozen_ram_wr", 32'(ram_if.ram_wr), 32'd0);
        end else begin
            if (ram_if.ram_wr) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", ram_if.ram_addr, w.a);
                    chk("wr_data", 32'(ram_if.ram_dout), 32'(w.d));
                end
            end
            if (stall_req) begin
                scnt++;
                if (exp_q.size() > 0 && exp_q[0].kind == 1) begin
                    if (raq.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
                    else chk("rd_addr", ram_if.ram_addr, raq.pop_front());
                end
            end else if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.kind != 2) begin
                    chk("wb_data", wb_rd_data, e.data);
                    chk("wb_rd", 32'(wb_rd_addr), 32'(e.rd));
                end
                chk("wb_we", 32'(wb_rd_write_enable), 32'(e.we));
                chk("stall_cycles", scnt, e.stalls);
                if (e.kind == 0) begin
                    chk("alu_ram_wr", 32'(ram_if.ram_wr), 32'd0);
                    chk("alu_ram_addr", ram_if.ram_addr, 32'd0);
                end
                scnt = 0;
                done_cnt++;
            end
        end
        if (end_chk && !end_done) begin
            chk("exp_left", exp_q.size(), 32'd0);
            chk("writes_left", wq.size(), 32'd0);
            chk("reads_left", raq.size(), 32'd0);
            end_done = 1;
        end
    end

    // kind: 0 alu, 1 load, 2 store (both=1 also raises load_enable).
    // fz/flen: drop rdy at cycle fz of the instruction for flen cycles.
    task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input logic we,
                         input bit both, input int fz, input int flen);
        exp_t        e;
        int          n;
        int          cyc;
        logic [31:0] v;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e.kind = kind;
        e.rd   = rd;
        e.data = data;
        e.we   = we && (rd != 5'd0);
        e.stalls = 0;
        if (kind == 1) begin
            v = 32'd0;
            for (int k = 0; k < n; k++) begin
                v = v | (32'(mrd(addr + 32'(k))) << (8 * k));
                raq.push_back(addr + 32'(k));
            end
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.data   = v;
            e.stalls = n;
        end else if (kind == 2) begin
            for (int k = 0; k < n; k++) begin
                wq.push_back({addr + 32'(k), data[8*k +: 8]});
                mmem[(addr + 32'(k)) & 32'hFFF] = data[8*k +: 8];
                mval[(addr + 32'(k)) & 32'hFFF] = 1'b1;
            end
            e.we     = 1'b0;
            e.stalls = n - 1;
        end
        exp_q.push_back(e);
        issued++;
        mem_data            = data;
        mem_load_enable     = (kind == 1) || (kind == 2 && both);
        mem_store_enable    = (kind == 2);
        mem_load_store_addr = addr;
        mem_funct3          = f3;
        mem_rd_addr         = rd;
        mem_rd_write_enable = we;
        cyc = 0;
        forever begin
            if (cyc == fz) rdy = 1'b0;
            if (cyc == fz + flen) rdy = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (done_cnt == issued) break;
            if (cyc > 100) begin
                $display("FAIL timeout: instruction %0d never completed", issued);
                $fatal(1, "timeout");
            end
        end
    endtask

    logic [2:0] f3_tab[8];

    initial begin
        f3_tab = '{FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU, 3'b011, 3'b110, 3'b111};
        // Reset with a store presented: nothing may reach the RAM.
        mem_store_enable    = 1'b1;
        mem_load_store_addr = 32'h55;
        mem_data            = 32'hCAFE_F00D;
        mem_funct3          = FUNCT3_W;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_store_enable = 1'b0;
        @(posedge clk); #1;

        issue(0, FUNCT3_W, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_W, 32'h100, 32'h0, 5'd7, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_B, 32'h20, 32'h0, 5'd8, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_BU, 32'h20, 32'h0, 5'd8, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_H, 32'h21, 32'h0, 5'd9, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_HU, 32'h21, 32'h0, 5'd9, 1'b1, 0, -1, 0);
        issue(2, FUNCT3_H, 32'h3FF, 32'hAABB_CCDD, 5'd10, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_HU, 32'h3FF, 32'h0, 5'd11, 1'b1, 0, -1, 0);
        issue(2, FUNCT3_W, 32'hFFFF_FFFE, 32'h0102_0304, 5'd12, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_W, 32'hFFFF_FFFE, 32'h0, 5'd13, 1'b1, 0, -1, 0);
        issue(2, FUNCT3_B, 32'h40, 32'h0000_00EE, 5'd1, 1'b1, 1, -1, 0);
        issue(0, FUNCT3_W, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1, 0, -1, 0);
        issue(1, FUNCT3_W, 32'h100, 32'h0, 5'd14, 1'b1, 0, 2, 3);

        // Abort an LW with reset in its third cycle.
        mem_load_enable     = 1'b1;
        mem_store_enable    = 1'b0;
        mem_load_store_addr = 32'h200;
        mem_funct3          = FUNCT3_W;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1, FUNCT3_W, 32'h100, 32'h0, 5'd15, 1'b1, 0, -1, 0);

        for (int i = 0; i < 200; i++) begin
            int          kind;
            int          fz;
            int          flen;
            logic [31:0] a;
            kind = int'($urandom_range(2, 0));
            case ($urandom_range(3, 0))
                0, 1:    a = 32'($urandom_range(63, 0));
                2:       a = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
                default: a = $urandom;
            endcase
            fz = -1;
            flen = 0;
            if ($urandom_range(7, 0) == 0) begin
                fz   = int'($urandom_range(4, 0));
                flen = int'($urandom_range(3, 1));
            end
            issue(kind, f3_tab[$urandom_range(7, 0)], a, $urandom, 5'($urandom_range(31, 0)),
                  1'($urandom_range(1, 0)), bit'($urandom_range(1, 0)), fz, flen);
        end

        mem_load_enable  = 1'b0;
        mem_store_enable = 1'b0;
        repeat (3) @(posedge clk);
        end_chk = 1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
